esm_issue_scheduler: RTL
========================

# esm_issue_scheduler

Issue scheduler in front of the ESM dependency core. It accepts decoded instructions over a valid/ready handshake and allocates each one a free buffer slot, then drives that slot's index and instruction fields into the ESM core. It watches the core's `ready_positions` vector and issues dependency-free slots to the execute stage in round-robin order. Slots are freed on a completion strobe from execute.

## Interface
Parameters:
- `bs`, 16: buffer slots; power of two, at least 2. `IW = $clog2(bs)`.
- `Instr_word_size`, 32: instruction width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  scheduler can accept an instruction.
- `in_instr`  in  Instr_word_size  instruction word.
- `in_alusrc`, `in_regwrite`  in  1 each  decode controls carried with `in_instr`.
- `core_we`  out  1  one-cycle strobe: ESM core records the instruction now on `core_*` into slot `core_index`.
- `core_instr`  out  Instr_word_size  to ESM core `Instr_in`.
- `core_alusrc`, `core_regwrite`  out  1 each  to ESM core.
- `core_index`  out  IW  to ESM core `buffer_index`.
- `core_ready_positions`  in  bs  from ESM core; bit i = slot i has no outstanding dependency.
- `issue_valid`  out  1  a slot is presented for issue.
- `issue_ready`  in  1  execute accepts the presented slot.
- `issue_index`  out  IW  presented slot.
- `issue_instr`  out  Instr_word_size  stored instruction of the presented slot.
- `done_valid`  in  1  execute finished a slot.
- `done_index`  in  IW  finished slot.
- `occupancy`  out  IW+1  number of non-FREE slots.
- `full`, `empty`  out  1 each  `occupancy==bs`, `occupancy==0`.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- Each slot has a 2-bit state and an instruction store: FREE, WAIT (allocated, awaiting readiness), SEL (held in the issue register), ISSUED (executing).
- Reset (`rst`=0, async):
  - all slots FREE, round-robin pointer 0, instruction store 0;
  - `core_we`, `core_*`, `issue_valid`, `issue_index`, `issue_instr`, `err` = 0;
  - `occupancy`=0, `empty`=1, `full`=0, `in_ready`=1.
- `in_ready = !full`, combinational.
- Accept (`in_valid && in_ready`):
  - allocate the lowest-index FREE slot, using state at the start of the cycle;
  - store the instruction in the slot and set the slot to WAIT;
  - register `core_we`=1 together with `core_index`, `core_instr`, `core_alusrc`, `core_regwrite` for the next cycle;
  - otherwise `core_we`=0 and `core_*` hold their last values.
- Eligible slot i: state WAIT, `core_ready_positions[i]`=1, and not (`core_we` && `core_index`==i). The last term is a one-cycle settle window after the core write.
- Issue register load:
  - condition: `!issue_valid || issue_ready`;
  - winner: first eligible slot scanning from the pointer upward, modulo bs;
  - winner goes WAIT->SEL; `issue_valid`=1, `issue_index`, `issue_instr` loaded;
  - if no slot is eligible, `issue_valid` goes to 0.
- While `issue_valid && !issue_ready`: `issue_index` and `issue_instr` are held stable.
- Issue handshake (`issue_valid && issue_ready`): presented slot goes SEL->ISSUED; pointer becomes `issue_index+1` modulo bs. A new winner can load in the same edge.
- Done (`done_valid`):
  - slot in ISSUED goes to FREE;
  - `done_index` in any other state: ignored and `err` set.
- Simultaneous events in one edge:
  - accept, issue handshake, load and done are all applied;
  - a slot freed by done is not reallocated until the next cycle;
  - `occupancy` is updated as +accept −done.

## Timing
- Accept at edge N:
  - `core_we` high during cycle N→N+1;
  - the slot is excluded from eligibility at edge N+1;
  - earliest load at edge N+2, so `issue_valid` is visible after edge N+2.
- Issue outputs are registered. `issue_valid` can stay high back-to-back, giving one issue per cycle.
- `full`, `empty` and `occupancy` are registered and reflect the state after each edge. `in_ready` follows `full`.
- Reset asserted mid-operation: all state is cleared immediately; an in-flight handshake is discarded.

## Test plan
- Reset, then 3 accepts (slots 0,1,2) with `ready_positions`=0xFFFF and `issue_ready`=1:
  - `core_we` pulses with `core_index` 0,1,2;
  - issue order is 0,1,2;
  - first `issue_valid` appears 2 edges after the first accept.
- Fill 16 slots:
  - `full`=1, `in_ready`=0, `occupancy`=16;
  - `done_index`=5 (slot ISSUED) frees it;
  - the next accept gets slot 5.
- `ready_positions`=0x0008 and `issue_ready`=0 for 4 cycles:
  - `issue_index`=3 is held stable;
  - after the handshake, the pointer is 4.
- All slots eligible, pointer=14: issue order is 14,15,0,1 (wrap-around).
- Edge cases:
  - `done_valid` for a slot in WAIT sets `err`=1 and leaves the slot unchanged;
  - async `rst` low mid-issue clears all outputs within the same cycle.
- Same edge: done on slot 0, accept, and issue handshake, with slot 0 otherwise the lowest free slot:
  - the accept takes the next free slot, not 0;
  - `occupancy` is unchanged.

Source files
------------

// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler
// Issue scheduler placed in front of the ESM dependency core. Incoming
// decoded instructions are parked in a free buffer slot and forwarded to the
// core for dependency tracking. Slots the core reports as dependency-free are
// handed to execute in round-robin order. Slots are released by a completion
// strobe from execute.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        upstream handshake (in_ready = !full)
//   in_instr/in_alusrc/in_regwrite   decoded instruction and controls
//   core_we, core_index, core_instr, core_alusrc, core_regwrite
//                            one-cycle write of an accepted instruction into the core
//   core_ready_positions     per-slot "no outstanding dependency" from the core
//   issue_valid/issue_ready  execute handshake, issue_index/issue_instr presented slot
//   done_valid/done_index    execute completion of a slot
//   occupancy, full, empty   registered fill level of the buffer
//   err                      sticky protocol error (bad completion index)
module esm_issue_scheduler #(
  parameter int bs              = 16,
  parameter int Instr_word_size = 32,
  localparam int IW             = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] in_instr,
  input  logic                       in_alusrc,
  input  logic                       in_regwrite,
  output logic                       core_we,
  output logic [Instr_word_size-1:0] core_instr,
  output logic                       core_alusrc,
  output logic                       core_regwrite,
  output logic [IW-1:0]              core_index,
  input  logic [bs-1:0]              core_ready_positions,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [IW-1:0]              issue_index,
  output logic [Instr_word_size-1:0] issue_instr,
  input  logic                       done_valid,
  input  logic [IW-1:0]              done_index,
  output logic [IW:0]                occupancy,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SEL    = 2'd2;
  localparam logic [1:0] ST_ISSUED = 2'd3;

  logic [1:0]                 slot_state  [bs];
  logic [Instr_word_size-1:0] instr_store [bs];
  logic [IW-1:0]              rr_ptr;

  logic          accept;
  logic [IW-1:0] alloc_idx;
  logic [bs-1:0] elig;
  logic          load_en;
  logic          handshake;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic          done_ok;
  logic [IW:0]   occ_next;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign load_en   = !issue_valid || issue_ready;
  assign handshake = issue_valid && issue_ready;
  assign done_ok   = done_valid && (slot_state[done_index] == ST_ISSUED);
  assign occ_next  = occupancy + (IW+1)'(accept) - (IW+1)'(done_ok);

  // Lowest-index free slot. Scanning downward lets the last hit win, so the
  // smallest index ends up in alloc_idx. A slot freed by done this cycle is
  // still ISSUED here, so it is only reused from the next cycle on.
  always_comb begin
    alloc_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (slot_state[i] == ST_FREE) alloc_idx = IW'(i);
    end
  end

  // A waiting slot is eligible once the core reports it dependency-free,
  // except in the cycle right after its core write: the core's readiness bit
  // for that slot has not yet been recomputed for the new instruction.
  always_comb begin
    elig = '0;
    for (int i = 0; i < bs; i++) begin
      elig[i] = (slot_state[i] == ST_WAIT) && core_ready_positions[i] &&
                !(core_we && (core_index == IW'(i)));
    end
  end

  // Round-robin pick: first eligible slot at or after rr_ptr, wrapping.
  // Offsets are scanned downward so the smallest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = bs - 1; k >= 0; k--) begin
      scan_idx = rr_ptr + IW'(k);
      if (elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Per-slot lifecycle. The four events act on slots in four different
  // start-of-cycle states, so at most one of them touches any given slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) begin
        slot_state[i]  <= ST_FREE;
        instr_store[i] <= '0;
      end
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (accept && (alloc_idx == IW'(i))) begin
          slot_state[i]  <= ST_WAIT;
          instr_store[i] <= in_instr;
        end else if (load_en && win_found && (win_idx == IW'(i))) begin
          slot_state[i] <= ST_SEL;
        end else if (handshake && (issue_index == IW'(i))) begin
          slot_state[i] <= ST_ISSUED;
        end else if (done_ok && (done_index == IW'(i))) begin
          slot_state[i] <= ST_FREE;
        end
      end
    end
  end

  // Issue register and round-robin pointer. The index and instruction only
  // change on a load, so they stay put while execute stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid <= 1'b0;
      issue_index <= '0;
      issue_instr <= '0;
      rr_ptr      <= '0;
    end else begin
      if (handshake) rr_ptr <= issue_index + IW'(1);
      if (load_en) begin
        issue_valid <= win_found;
        if (win_found) begin
          issue_index <= win_idx;
          issue_instr <= instr_store[win_idx];
        end
      end
    end
  end

  // Core write port: a one-cycle strobe carrying the accepted instruction;
  // the data fields hold their last values between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_we       <= 1'b0;
      core_index    <= '0;
      core_instr    <= '0;
      core_alusrc   <= 1'b0;
      core_regwrite <= 1'b0;
    end else begin
      core_we <= accept;
      if (accept) begin
        core_index    <= alloc_idx;
        core_instr    <= in_instr;
        core_alusrc   <= in_alusrc;
        core_regwrite <= in_regwrite;
      end
    end
  end

  // Fill level and flags, all registered from the same next value so they
  // never disagree; err latches any completion for a slot not executing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err       <= 1'b0;
    end else begin
      occupancy <= occ_next;
      full      <= (occ_next == (IW+1)'(bs));
      empty     <= (occ_next == '0);
      if (done_valid && !done_ok) err <= 1'b1;
    end
  end

endmodule
